count_step_tracker: RTL and testbench

Observer for the 3-bit up/down counter value. It samples the counter output on the fast board clock and filters it for stability. Each accepted change is classified as an up step, a down step or an illegal jump (wrap-aware, mod 8), and the block keeps a wider signed position, a direction flag and a direction-reversal tally. It is the read-side companion to the clock-divided up/down counter: it sits beside it on the same board clock and feeds the display and status LEDs.

---
 rtl/count_track_pkg.sv | 14 +
 rtl/count_step_tracker_sync_debounce.sv | 66 ++++++
 rtl/count_step_tracker.sv | 124 ++++++++++++
 tb/tb_count_step_tracker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/count_track_pkg.sv
// Shared types and constants for the counter step tracker.
package count_track_pkg;

    typedef enum logic [1:0] {
        INIT,
        TRACK,
        FAULT
    } state_t;

    localparam logic [2:0] D_UP    = 3'd1;
    localparam logic [2:0] D_DN    = 3'd7;
    localparam logic [7:0] REV_MAX = 8'd255;

endpackage

// File: rtl/count_step_tracker_sync_debounce.sv
// Two-flop synchronizer followed by a stability filter; pulses accept once per
// newly stable value and presents that value on the same cycle.
module sync_debounce #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic             accept,
    output logic [WIDTH-1:0] value
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             accept_q, accept_d;

    always_comb begin
        s1_d     = din;
        s2_d     = s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        accept_d = 1'b0;

        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = 4'd1;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 4'd1;
        end

        // value_q remembers the last accepted value so each new value fires once
        if (cnt_q == STABLE && cand_q != value_q) begin
            accept_d = 1'b1;
            value_d  = cand_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            accept_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            accept_q <= accept_d;
        end
    end

    assign accept = accept_q;
    assign value  = value_q;

endmodule

// File: rtl/count_step_tracker.sv
// Observer for a 3-bit up/down counter: classifies each stable change as an
// up/down step or illegal jump and tracks position, direction and reversals.
module count_step_tracker
    import count_track_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned POS_W         = 8
) (
    input  logic             c,
    input  logic             reset,
    input  logic [2:0]       cnt_in,
    input  logic             clear,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step_pulse,
    output logic             err,
    output logic [7:0]       rev_count
);

    logic       acc_evt;
    logic [2:0] new_val;

    sync_debounce #(
        .WIDTH         (3),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync_debounce (
        .clk    (c),
        .rst_n  (reset),
        .din    (cnt_in),
        .accept (acc_evt),
        .value  (new_val)
    );

    state_t           state_q, state_d;
    logic [2:0]       acc_q, acc_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [7:0]       rev_q, rev_d;
    logic             have_prev_q, have_prev_d;
    logic [2:0]       delta;
    logic             is_up;

    assign delta = new_val - acc_q;
    assign is_up = (delta == D_UP);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_d       = err_q;
        rev_d       = rev_q;
        have_prev_d = have_prev_q;

        if (acc_evt) begin
            acc_d = new_val;
        end

        // clear overrides any step classification in the same cycle
        if (clear) begin
            pos_d       = '0;
            rev_d       = '0;
            err_d       = 1'b0;
            have_prev_d = 1'b0;
            if (state_q == FAULT) begin
                state_d = INIT;
            end else if (state_q == INIT && acc_evt) begin
                state_d = TRACK;
            end
        end else if (acc_evt) begin
            unique case (state_q)
                INIT: state_d = TRACK;
                TRACK: begin
                    if (delta == D_UP || delta == D_DN) begin
                        pos_d       = is_up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                        dir_d       = is_up;
                        step_d      = 1'b1;
                        have_prev_d = 1'b1;
                        if (have_prev_q && (is_up != dir_q) && (rev_q != REV_MAX)) begin
                            rev_d = rev_q + 8'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end
                end
                FAULT: state_d = FAULT;
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge c or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            acc_q       <= '0;
            pos_q       <= '0;
            dir_q       <= 1'b1;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            rev_q       <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            rev_q       <= rev_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign pos        = pos_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign err        = err_q;
    assign rev_count  = rev_q;

endmodule

// File: tb/tb_count_step_tracker.sv
// Directed self-checking bench for count_step_tracker: vector table plus
// hand-written glitch, clear/accept collision and async reset sequences.
module tb_count_step_tracker;
    import count_track_pkg::*;

    localparam int STABLE = 4;
    localparam int POSW   = 8;
    localparam int HOLD   = 20;

    logic            c;
    logic            reset;
    logic [2:0]      cnt_in;
    logic            clear;
    logic [POSW-1:0] pos;
    logic            dir;
    logic            step_pulse;
    logic            err;
    logic [7:0]      rev_count;

    count_step_tracker #(
        .STABLE_CYCLES (STABLE),
        .POS_W         (POSW)
    ) dut (
        .c          (c),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .clear      (clear),
        .pos        (pos),
        .dir        (dir),
        .step_pulse (step_pulse),
        .err        (err),
        .rev_count  (rev_count)
    );

    typedef struct {
        bit       clr;
        bit [2:0] val;
        int       exp_pos;
        bit       exp_dir;
        bit       exp_err;
        int       exp_rev;
        int       exp_strobes;
        state_t   exp_st;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes  = 0;
    int last_strobe_cyc = -1;

    initial c = 1'b0;
    always #5 c = ~c;

    always @(posedge c) cyc <= cyc + 1;

    always @(negedge c) begin
        if (step_pulse === 1'b1) begin
            strobes         = strobes + 1;
            last_strobe_cyc = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge c);
            #1;
        end
    endtask

    vec_t vt[14];
    int   s0;
    int   change_cyc;

    initial begin
        // up run with wrap, reversals, illegal jump, FAULT, clear and re-arm
        vt[0]  = '{0, 3'd5, 0, 1, 0, 0, 0, TRACK};
        vt[1]  = '{0, 3'd6, 1, 1, 0, 0, 1, TRACK};
        vt[2]  = '{0, 3'd7, 2, 1, 0, 0, 1, TRACK};
        vt[3]  = '{0, 3'd0, 3, 1, 0, 0, 1, TRACK};
        vt[4]  = '{0, 3'd1, 4, 1, 0, 0, 1, TRACK};
        vt[5]  = '{0, 3'd2, 5, 1, 0, 0, 1, TRACK};
        vt[6]  = '{0, 3'd1, 4, 0, 0, 1, 1, TRACK};
        vt[7]  = '{0, 3'd0, 3, 0, 0, 1, 1, TRACK};
        vt[8]  = '{0, 3'd7, 2, 0, 0, 1, 1, TRACK};
        vt[9]  = '{0, 3'd0, 3, 1, 0, 2, 1, TRACK};
        vt[10] = '{0, 3'd3, 3, 1, 1, 2, 0, FAULT};
        vt[11] = '{0, 3'd4, 3, 1, 1, 2, 0, FAULT};
        vt[12] = '{1, 3'd7, 0, 1, 0, 0, 0, TRACK};
        vt[13] = '{0, 3'd0, 1, 1, 0, 0, 1, TRACK};

        reset  = 1'b0;
        clear  = 1'b0;
        cnt_in = 3'd0;
        tick(3);
        chk("reset_pos", int'(pos), 0);
        chk("reset_dir", int'(dir), 1);
        chk("reset_step", int'(step_pulse), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_rev", int'(rev_count), 0);
        chk("reset_state", int'(dut.state_q), int'(INIT));
        reset = 1'b1;
        tick(2);

        for (int i = 0; i < 14; i++) begin
            if (vt[i].clr) begin
                clear = 1'b1;
                tick(1);
                clear = 1'b0;
                tick(1);
                chk($sformatf("v%0d_clr_err", i), int'(err), 0);
                chk($sformatf("v%0d_clr_state", i), int'(dut.state_q), int'(INIT));
            end
            s0         = strobes;
            cnt_in     = vt[i].val;
            change_cyc = cyc;
            tick(HOLD);
            chk($sformatf("v%0d_pos", i), int'(pos), vt[i].exp_pos);
            chk($sformatf("v%0d_dir", i), int'(dir), int'(vt[i].exp_dir));
            chk($sformatf("v%0d_err", i), int'(err), int'(vt[i].exp_err));
            chk($sformatf("v%0d_rev", i), int'(rev_count), vt[i].exp_rev);
            chk($sformatf("v%0d_strobes", i), strobes - s0, vt[i].exp_strobes);
            chk($sformatf("v%0d_state", i), int'(dut.state_q), int'(vt[i].exp_st));
            if (vt[i].exp_strobes > 0)
                chk($sformatf("v%0d_latency", i), last_strobe_cyc - change_cyc, STABLE + 4);
        end

        // short glitch to 1 while holding 0 must be ignored
        s0     = strobes;
        cnt_in = 3'd1;
        tick(STABLE - 1);
        cnt_in = 3'd0;
        tick(HOLD);
        chk("glitch_strobes", strobes - s0, 0);
        chk("glitch_pos", int'(pos), 1);
        chk("glitch_err", int'(err), 0);

        // clear lands on the same edge that samples the accept pulse
        s0     = strobes;
        cnt_in = 3'd1;
        tick(STABLE + 3);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(HOLD);
        chk("coinc_pos", int'(pos), 0);
        chk("coinc_strobes", strobes - s0, 0);
        chk("coinc_err", int'(err), 0);
        chk("coinc_state", int'(dut.state_q), int'(TRACK));

        s0     = strobes;
        cnt_in = 3'd2;
        tick(HOLD);
        chk("after_coinc_pos", int'(pos), 1);
        chk("after_coinc_strobes", strobes - s0, 1);
        chk("after_coinc_err", int'(err), 0);

        cnt_in = 3'd5;
        tick(HOLD);
        chk("jump_err", int'(err), 1);
        chk("jump_pos", int'(pos), 1);

        // async reset in mid-cycle, checked before the next clock edge
        @(posedge c);
        #3;
        reset = 1'b0;
        #1;
        chk("areset_pos", int'(pos), 0);
        chk("areset_dir", int'(dir), 1);
        chk("areset_err", int'(err), 0);
        chk("areset_rev", int'(rev_count), 0);
        chk("areset_step", int'(step_pulse), 0);
        chk("areset_state", int'(dut.state_q), int'(INIT));
        tick(2);
        reset = 1'b1;

        s0 = strobes;
        tick(HOLD);
        chk("rearm_strobes", strobes - s0, 0);
        chk("rearm_pos", int'(pos), 0);
        chk("rearm_state", int'(dut.state_q), int'(TRACK));

        s0         = strobes;
        cnt_in     = 3'd6;
        change_cyc = cyc;
        tick(HOLD);
        chk("post_reset_pos", int'(pos), 1);
        chk("post_reset_strobes", strobes - s0, 1);
        chk("post_reset_latency", last_strobe_cyc - change_cyc, STABLE + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
